// File: rtl/rainbow_pwm_array_if.sv
// rainbow_pwm_array_if: control inputs and PWM/wheel outputs of the colour wheel.
// The bright port exists only when BRIGHTNESS_EN is defined.
interface rainbow_pwm_array_if #(
    parameter int CH    = 2,
    parameter int PW    = 8,
    parameter int DIV_W = 24
);
    logic [DIV_W-1:0] period;
    logic [CH-1:0]    en_tgl;
    logic [CH-1:0]    rev_tgl;
    logic             hold;
`ifdef BRIGHTNESS_EN
    logic [PW-1:0]    bright;
`endif
    logic [CH-1:0]    r;
    logic [CH-1:0]    g;
    logic [CH-1:0]    b;
    logic             step;
    logic [PW+1:0]    wheel;

    modport master (
        output period, en_tgl, rev_tgl, hold,
`ifdef BRIGHTNESS_EN
        output bright,
`endif
        input  r, g, b, step, wheel
    );

    modport slave (
        input  period, en_tgl, rev_tgl, hold,
`ifdef BRIGHTNESS_EN
        input  bright,
`endif
        output r, g, b, step, wheel
    );
endinterface

// File: rtl/rainbow_pwm_array.sv
// rainbow_pwm_array: N-channel RGB colour wheel with a shared-counter PWM.
// Optional BRIGHTNESS_EN adds a global bright scale on the target duties.
module rainbow_pwm_array #(
    parameter int CH     = 2,
    parameter int PW     = 8,
    parameter int DIV_W  = 24,
    parameter int OFFSET = 0
) (
    input logic                clk,
    input logic                rst,
    rainbow_pwm_array_if.slave bus
);
    localparam int MAX = (1 << PW) - 1;
    localparam int TRI = 3 * MAX;
    localparam logic [PW-1:0] L_MAX   = PW'(MAX);
    localparam logic [PW-1:0] L_LAST  = PW'(MAX - 1);
    localparam logic [PW-1:0] L_Q1    = PW'(MAX);
    localparam logic [PW-1:0] L_Q2    = PW'(2 * MAX);
    localparam logic [PW+1:0] L_WLAST = (PW+2)'(TRI - 1);
    localparam logic [PW+2:0] L_M1    = (PW+3)'(MAX);
    localparam logic [PW+2:0] L_M2    = (PW+3)'(2 * MAX);
    localparam logic [PW+2:0] L_TRI   = (PW+3)'(TRI);

    logic [DIV_W-1:0]      r_pre;
    logic                  r_step;
    logic [PW+1:0]         r_wheel;
    logic [CH-1:0]         r_en;
    logic [CH-1:0]         r_rev;
    logic [PW-1:0]         r_pwm;
    logic [CH-1:0][PW-1:0] r_dr;
    logic [CH-1:0][PW-1:0] r_dg;
    logic [CH-1:0][PW-1:0] r_db;
    logic [CH-1:0]         r_r;
    logic [CH-1:0]         r_g;
    logic [CH-1:0]         r_b;

    logic                  w_tick;
    logic [CH-1:0][PW-1:0] w_tr;
    logic [CH-1:0][PW-1:0] w_tg;
    logic [CH-1:0][PW-1:0] w_tb;
    logic [3*PW-1:0]       w_c;

    function automatic logic [PW+2:0] f_pos(input logic [PW+1:0] w,
                                            input int i);
        logic [PW+2:0] p;
        p = {1'b0, w} + (PW+3)'((i * OFFSET) % TRI);
        if (p >= L_TRI)
            p = p - L_TRI;
        return p;
    endfunction

    // q fits in PW bits, so the low-bit subtraction is exact
    function automatic logic [3*PW-1:0] f_colour(input logic [PW+2:0] p,
                                                 input logic rv);
        logic [1:0]      seg;
        logic [PW-1:0]   q;
        logic [PW-1:0]   nq;
        logic [PW-1:0]   z;
        logic [3*PW-1:0] c;
        seg = 2'd0;
        q   = '0;
        z   = '0;
        c   = '0;
        unique case (1'b1)
            (p < L_M1): begin
                seg = 2'd0;
                q   = p[PW-1:0];
            end
            (p >= L_M1 && p < L_M2): begin
                seg = 2'd1;
                q   = p[PW-1:0] - L_Q1;
            end
            default: begin
                seg = 2'd2;
                q   = p[PW-1:0] - L_Q2;
            end
        endcase
        nq = L_MAX - q;
        unique case (seg)
            2'd0:    c = rv ? {nq, q, z} : {nq, z, q};
            2'd1:    c = rv ? {z, nq, q} : {z, q, nq};
            default: c = rv ? {q, z, nq} : {q, nq, z};
        endcase
        return c;
    endfunction

`ifdef BRIGHTNESS_EN
    function automatic logic [PW-1:0] f_scale(input logic [PW-1:0] c,
                                              input logic [PW-1:0] k);
        logic [2*PW-1:0] m;
        m = {{PW{1'b0}}, c} * {{PW{1'b0}}, k};
        return PW'(m >> PW);
    endfunction
`endif

    assign w_tick = (r_pre >= bus.period);

    always_comb begin
        w_tr = '0;
        w_tg = '0;
        w_tb = '0;
        w_c  = '0;
        for (int i = 0; i < CH; i++) begin
            w_c = r_en[i] ? f_colour(f_pos(r_wheel, i), r_rev[i]) : '0;
`ifdef BRIGHTNESS_EN
            w_tr[i] = f_scale(w_c[3*PW-1 -: PW], bus.bright);
            w_tg[i] = f_scale(w_c[2*PW-1 -: PW], bus.bright);
            w_tb[i] = f_scale(w_c[PW-1:0], bus.bright);
`else
            w_tr[i] = w_c[3*PW-1 -: PW];
            w_tg[i] = w_c[2*PW-1 -: PW];
            w_tb[i] = w_c[PW-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre   <= '0;
            r_step  <= 1'b0;
            r_wheel <= '0;
            r_en    <= '1;
            r_rev   <= '0;
            r_pwm   <= '0;
            r_dr    <= '0;
            r_dg    <= '0;
            r_db    <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else begin
            r_pre  <= w_tick ? '0 : r_pre + 1'b1;
            r_step <= w_tick & ~bus.hold;
            if (r_step)
                r_wheel <= (r_wheel == L_WLAST) ? '0 : r_wheel + 1'b1;
            r_en  <= r_en ^ bus.en_tgl;
            r_rev <= r_rev ^ bus.rev_tgl;
            r_pwm <= (r_pwm == L_LAST) ? '0 : r_pwm + 1'b1;
            // duties change only at the frame boundary
            if (r_pwm == L_LAST) begin
                r_dr <= w_tr;
                r_dg <= w_tg;
                r_db <= w_tb;
            end
            for (int i = 0; i < CH; i++) begin
                r_r[i] <= (r_dr[i] > r_pwm);
                r_g[i] <= (r_dg[i] > r_pwm);
                r_b[i] <= (r_db[i] > r_pwm);
            end
        end
    end

    assign bus.r     = r_r;
    assign bus.g     = r_g;
    assign bus.b     = r_b;
    assign bus.step  = r_step;
    assign bus.wheel = r_wheel;
endmodule

// File: tb/tb_rainbow_pwm_array.sv
// tb_rainbow_pwm_array: random and directed stimulus for rainbow_pwm_array,
// compared with an arithmetic model of wheel, step and per-frame high counts.
`timescale 1ns/1ps
module tb_rainbow_pwm_array;
    localparam int CH     = 2;
    localparam int PW     = 8;
    localparam int DIV_W  = 24;
    localparam int OFFSET = 255;
    localparam int MAX    = (1 << PW) - 1;
    localparam int TRI    = 3 * MAX;

    logic clk = 1'b0;
    logic rst;

    rainbow_pwm_array_if #(.CH(CH), .PW(PW), .DIV_W(DIV_W)) bus ();

    rainbow_pwm_array #(
        .CH(CH), .PW(PW), .DIV_W(DIV_W), .OFFSET(OFFSET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int m_pre, m_wheel, m_step, n, prev_wheel;
    bit [CH-1:0] m_en, m_rev;
    bit wrap_seen;
    int ex[CH][3];
    int pend[CH][3];
    int cnt[CH][3];
    int lastc[CH][3];

    function automatic int sc(input int v);
`ifdef BRIGHTNESS_EN
        return (v * int'(bus.bright)) >> PW;
`else
        return v;
`endif
    endfunction

    // colour index c: 0=r 1=g 2=b
    function automatic int colour(input int ch, input int c);
        int p, seg, q, hi;
        int t[3];
        p   = (m_wheel + ch * OFFSET) % TRI;
        seg = p / MAX;
        q   = p % MAX;
        hi  = MAX - q;
        if (!m_en[ch])
            return 0;
        if (!m_rev[ch]) begin
            case (seg)
                0:       t = '{hi, 0, q};
                1:       t = '{0, q, hi};
                default: t = '{q, hi, 0};
            endcase
        end else begin
            case (seg)
                0:       t = '{hi, q, 0};
                1:       t = '{0, hi, q};
                default: t = '{q, 0, hi};
            endcase
        end
        return sc(t[c]);
    endfunction

    task automatic init_model();
        m_pre = 0;
        m_wheel = 0;
        m_step = 0;
        n = 0;
        prev_wheel = 0;
        m_en = '1;
        m_rev = '0;
        for (int i = 0; i < CH; i++)
            for (int c = 0; c < 3; c++) begin
                ex[i][c] = 0;
                pend[i][c] = 0;
                cnt[i][c] = 0;
            end
    endtask

    task automatic tick();
        bit t;
        if ((n + 1) % MAX == 0)
            for (int i = 0; i < CH; i++)
                for (int c = 0; c < 3; c++)
                    pend[i][c] = colour(i, c);
        t = (m_pre >= int'(bus.period));
        if (m_step != 0)
            m_wheel = (m_wheel + 1) % TRI;
        m_pre = t ? 0 : m_pre + 1;
        m_step = (t && !bus.hold) ? 1 : 0;
        m_en ^= bus.en_tgl;
        m_rev ^= bus.rev_tgl;
        @(posedge clk);
        n++;
        @(negedge clk);
        chk("wheel", int'(bus.wheel), m_wheel);
        chk("step", int'(bus.step), m_step);
        if (prev_wheel == TRI - 1 && int'(bus.wheel) == 0)
            wrap_seen = 1'b1;
        prev_wheel = int'(bus.wheel);
        for (int i = 0; i < CH; i++) begin
            cnt[i][0] += int'(bus.r[i]);
            cnt[i][1] += int'(bus.g[i]);
            cnt[i][2] += int'(bus.b[i]);
        end
        if (n % MAX == 0)
            for (int i = 0; i < CH; i++)
                for (int c = 0; c < 3; c++) begin
                    chk($sformatf("frame ch%0d c%0d", i, c), cnt[i][c], ex[i][c]);
                    lastc[i][c] = cnt[i][c];
                    cnt[i][c] = 0;
                    ex[i][c] = pend[i][c];
                end
    endtask

    task automatic chk_rgb(input string tag, input int ch,
                           input int er, input int eg, input int eb);
        chk({tag, "_r"}, lastc[ch][0], sc(er));
        chk({tag, "_g"}, lastc[ch][1], sc(eg));
        chk({tag, "_b"}, lastc[ch][2], sc(eb));
    endtask

    initial begin
        bus.period = 3;
        bus.en_tgl = '0;
        bus.rev_tgl = '0;
        bus.hold = 1'b0;
`ifdef BRIGHTNESS_EN
        bus.bright = '1;
`endif
        wrap_seen = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_wheel", int'(bus.wheel), 0);
        chk("rst_step", int'(bus.step), 0);
        chk("rst_r", int'(bus.r), 0);
        chk("rst_g", int'(bus.g), 0);
        chk("rst_b", int'(bus.b), 0);
        @(negedge clk);
        rst = 1'b1;
        init_model();

        // full wheel revolution and wrap
        repeat (TRI * 4 + 60) tick();
        chk("wrap", int'(wrap_seen), 1);

        for (int k = 0; k < 4000 && m_wheel != 100; k++)
            tick();
        chk("reach100", int'(bus.wheel), 100);
        bus.hold = 1'b1;
        repeat (3 * MAX) tick();
        chk("hold_wheel", int'(bus.wheel), 100);
        chk_rgb("w100_ch0", 0, 155, 0, 100);
        chk_rgb("w100_ch1", 1, 0, 100, 155);

        bus.rev_tgl = 2'b01;
        tick();
        bus.rev_tgl = '0;
        repeat (3 * MAX) tick();
        chk_rgb("rev_ch0", 0, 155, 100, 0);

        repeat (100) tick();
        bus.en_tgl = 2'b10;
        tick();
        bus.en_tgl = '0;
        repeat (3 * MAX) tick();
        chk_rgb("dis_ch1", 1, 0, 0, 0);
        bus.en_tgl = 2'b10;
        tick();
        bus.en_tgl = '0;
        repeat (3 * MAX) tick();
        chk_rgb("ena_ch1", 1, 0, 100, 155);
        bus.hold = 1'b0;

        // lowering period below pre_cnt ticks on the next clock
        bus.period = 1000;
        for (int k = 0; k < 1500 && m_pre != 500; k++)
            tick();
        chk("pre500_step", int'(bus.step), 0);
        bus.period = 2;
        tick();
        chk("pdrop_step", int'(bus.step), 1);

        repeat (4000) begin
            if ($urandom % 8 == 0)
                bus.period = DIV_W'($urandom % 5);
            bus.en_tgl = ($urandom % 32 == 0) ? CH'($urandom) : '0;
            bus.rev_tgl = ($urandom % 32 == 0) ? CH'($urandom) : '0;
            if ($urandom % 200 == 0)
                bus.hold = ~bus.hold;
            tick();
        end
        bus.en_tgl = '0;
        bus.rev_tgl = '0;
        bus.hold = 1'b0;

        // reset in the middle of a frame
        repeat (100) tick();
        #1 rst = 1'b0;
        #1;
        chk("mrst_r", int'(bus.r), 0);
        chk("mrst_g", int'(bus.g), 0);
        chk("mrst_b", int'(bus.b), 0);
        chk("mrst_wheel", int'(bus.wheel), 0);
        @(negedge clk);
        rst = 1'b1;
        init_model();
        bus.period = 0;
        repeat (3 * MAX) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
